// File: rtl/hamming_enc_engine.sv
// Sequential Hamming(16,11) SECDED encoder: reads 11-bit messages as byte pairs,
// writes the 16-bit codewords back as byte pairs, four cycles per message.
module hamming_enc_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);

    typedef enum logic [2:0] {RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [10:0]   data_q;
    logic [10:0]   data_d;
    logic [15:0]   cw_d;
    logic [AW-1:0] addr_q;
    logic          wr_en_q;
    logic [7:0]    wr_data_q;
    logic          done_q;

    // d[k-1] holds message bit dk; returns {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[10:4];
        p4 = ^{d[10:7], d[3:1]};
        p2 = d[10] ^ d[9] ^ d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
        p1 = d[10] ^ d[8] ^ d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
        p0 = ^{d, p8, p4, p2, p1};
        return {d[10:4], p8, d[3:1], p4, d[0], p2, p1, p0};
    endfunction

    function automatic logic [AW-1:0] byte_addr(input int base, input logic [IW-1:0] idx,
                                                input logic hi);
        return AW'(base + 2 * int'(idx) + int'(hi));
    endfunction

    // Next data register value; the low codeword byte needs d[11:9] in the same edge it is captured.
    always_comb begin
        data_d = data_q;
        case (state_q)
            RD_LO:   data_d[7:0]  = mem_rd_data;
            RD_HI:   data_d[10:8] = mem_rd_data[2:0];
            default: ;
        endcase
    end

    assign cw_d = encode(data_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RD_LO;
            idx_q     <= '0;
            data_q    <= '0;
            addr_q    <= AW'(SRC_BASE);
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                RD_LO: begin
                    data_q  <= data_d;
                    addr_q  <= byte_addr(SRC_BASE, idx_q, 1'b1);
                    state_q <= RD_HI;
                end
                RD_HI: begin
                    data_q    <= data_d;
                    addr_q    <= byte_addr(DST_BASE, idx_q, 1'b0);
                    wr_en_q   <= 1'b1;
                    wr_data_q <= cw_d[7:0];
                    state_q   <= WR_LO;
                end
                WR_LO: begin
                    addr_q    <= byte_addr(DST_BASE, idx_q, 1'b1);
                    wr_data_q <= cw_d[15:8];
                    state_q   <= WR_HI;
                end
                WR_HI: begin
                    wr_en_q   <= 1'b0;
                    wr_data_q <= '0;
                    if (idx_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        addr_q  <= byte_addr(SRC_BASE, idx_q + IW'(1), 1'b0);
                        state_q <= RD_LO;
                    end
                end
                DONE: ;
                default: state_q <= RD_LO;
            endcase
        end
    end

    assign done        = done_q;
    assign mem_addr    = addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Scoreboard bench for hamming_enc_engine: a byte memory model, expected writes
// queued per run, and an independent position-based Hamming reference.
module tb_hamming_enc_engine;

    localparam int NUM_MSG  = 15;
    localparam int SRC_BASE = 0;
    localparam int DST_BASE = 30;
    localparam int AW       = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;

    logic [7:0]  mem [0:255];
    logic [7:0]  src_img [0:2*NUM_MSG-1];
    logic [10:0] msg_d [0:NUM_MSG-1];
    logic [15:0] sb_q [$];
    logic        sb_en = 1'b0;
    int          wr_count;
    int          checks = 0;
    int          errors = 0;

    hamming_enc_engine #(
        .NUM_MSG(NUM_MSG), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .done(done), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i < 2*NUM_MSG) ? src_img[i] : 8'h00;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: codeword bit j is Hamming position j; data fills non-power-of-two positions.
    function automatic logic [15:0] ref_cw(input logic [10:0] d);
        logic [15:0] c;
        int k;
        c = '0;
        k = 0;
        for (int j = 3; j < 16; j++) begin
            if ((j & (j - 1)) != 0) begin
                c[j] = d[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2)
            for (int j = 3; j < 16; j++)
                if ((j & p) != 0 && (j & (j - 1)) != 0) c[p] = c[p] ^ c[j];
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [3:0] syndrome(input logic [15:0] c);
        logic [3:0] s;
        s = '0;
        for (int j = 1; j < 16; j++)
            if (c[j]) s = s ^ 4'(j);
        return s;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        logic [10:0] d;
        int k;
        d = '0;
        k = 0;
        for (int j = 3; j < 16; j++) begin
            if ((j & (j - 1)) != 0) begin
                d[k] = c[j];
                k++;
            end
        end
        return d;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            wr_count <= 0;
        end else if (sb_en && mem_wr_en) begin
            wr_count <= wr_count + 1;
            $display("wr addr=%0d data=%h", mem_addr, mem_wr_data);
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[15:8]));
                check("wr_data", 32'(mem_wr_data), 32'(e[7:0]));
            end
        end
    end

    task automatic push_cw(input int i, input logic [15:0] cw);
        sb_q.push_back({8'(DST_BASE + 2*i), cw[7:0]});
        sb_q.push_back({8'(DST_BASE + 2*i + 1), cw[15:8]});
    endtask

    task automatic run_once(input bit abort, input bit directed);
        logic [15:0] exp_cw [0:NUM_MSG-1];
        reset = 1'b1;
        sb_en = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        if (abort) begin
            @(negedge clk) reset = 1'b0;
            repeat (25) @(posedge clk);
            @(negedge clk) reset = 1'b1;
            @(posedge clk); #1;
            check("abort_wr_en", 32'(mem_wr_en), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_addr", 32'(mem_addr), 32'(SRC_BASE));
            @(posedge clk); #1;
            check("abort_hold_wr_en", 32'(mem_wr_en), 32'd0);
        end
        for (int i = 0; i < NUM_MSG; i++) exp_cw[i] = ref_cw(msg_d[i]);
        if (directed) begin
            exp_cw[0] = 16'h0000;
            exp_cw[1] = 16'hFFFF;
            exp_cw[2] = 16'h000F;
            exp_cw[3] = 16'h8117;
            exp_cw[4] = 16'h0000;
        end
        for (int i = 0; i < NUM_MSG; i++) push_cw(i, exp_cw[i]);
        @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_wr_en", 32'(mem_wr_en), 32'd0);
        reset = 1'b0;
        sb_en = 1'b1;
        repeat (4*NUM_MSG - 1) @(posedge clk);
        #1 check("done_early", 32'(done), 32'd0);
        @(posedge clk);
        #1 check("done_latency", 32'(done), 32'd1);
        repeat (4) @(posedge clk);
        #1 check("done_sticky", 32'(done), 32'd1);
        check("idle_wr_en", 32'(mem_wr_en), 32'd0);
        check("wr_pulses", 32'(wr_count), 32'(2*NUM_MSG));
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        sb_en = 1'b0;
        for (int i = 0; i < NUM_MSG; i++) begin
            logic [15:0] c;
            c = {mem[DST_BASE + 2*i + 1], mem[DST_BASE + 2*i]};
            check("mem_cw", 32'(c), 32'(exp_cw[i]));
            check("even_parity", 32'(^c), 32'd0);
            check("decode", {16'h0, syndrome(c), 1'b0, extract(c)}, {16'h0, 4'h0, 1'b0, msg_d[i]});
        end
    endtask

    task automatic load_random(input int first);
        for (int i = first; i < NUM_MSG; i++) begin
            logic [7:0] r;
            msg_d[i] = 11'($urandom_range(0, 2047));
            r = 8'($urandom);
            src_img[2*i]     = msg_d[i][7:0];
            src_img[2*i + 1] = {r[7:3], msg_d[i][10:8]};
        end
    endtask

    initial begin
        src_img[0] = 8'h00; src_img[1] = 8'h00; msg_d[0] = 11'h000;
        src_img[2] = 8'hFF; src_img[3] = 8'h07; msg_d[1] = 11'h7FF;
        src_img[4] = 8'h01; src_img[5] = 8'h00; msg_d[2] = 11'h001;
        src_img[6] = 8'h00; src_img[7] = 8'h04; msg_d[3] = 11'h400;
        src_img[8] = 8'h00; src_img[9] = 8'hF8; msg_d[4] = 11'h000;
        load_random(5);
        run_once(1'b0, 1'b1);
        load_random(0);
        run_once(1'b0, 1'b0);
        load_random(0);
        run_once(1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_enc_engine.md
Name: hamming_enc_engine

Overview:
- Sequential Hamming(16,11) SECDED encoder engine; the transmit side of the program-2 decoder flow.
- Walks NUM_MSG 11-bit messages stored as byte pairs in the byte-wide data memory and computes parity bits p8/p4/p2/p1 plus overall parity p0.
- Writes each 16-bit codeword back to data memory as a byte pair.
- Starts on reset release and raises done when the last codeword is written.

Parameters:
- NUM_MSG, 15: number of messages to encode.
- SRC_BASE, 0: byte address of message 0 low byte.
- DST_BASE, 30: byte address of codeword 0 low byte.
- AW, 8: data-memory address width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high; also acts as the start request (engine runs after it deasserts).
- done  output  1  ack; high when all codewords are written; sticky until reset.
- mem_addr  output  AW  data-memory byte address (read and write).
- mem_rd_data  input  8  data-memory read data; combinational, valid in the same cycle as mem_addr.
- mem_wr_en  output  1  byte write enable, sampled on clk rising edge.
- mem_wr_data  output  8  byte write data.

Behaviour:
- Reset values: done=0, mem_wr_en=0, mem_addr=SRC_BASE, mem_wr_data=0, msg index i=0, state=RD_LO, internal data register=0.
- Reset asserted mid-run aborts immediately. No further writes occur after the reset cycle. The run restarts from i=0 after deassert.
- Memory layout, input:
  - Message i low byte at SRC_BASE+2i holds d[8:1].
  - High byte at SRC_BASE+2i+1 holds d[11:9] in bits [2:0]; bits [7:3] are ignored.
- Memory layout, output:
  - Codeword bits [7:0] go to DST_BASE+2i.
  - Bits [15:8] go to DST_BASE+2i+1.
- Codeword: {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}, i.e. bit15..bit0.
- Parity equations:
  - p8 = ^d[11:5].
  - p4 = ^{d[11:8], d[4:2]}.
  - p2 = d11^d10^d7^d6^d4^d3^d1.
  - p1 = d11^d9^d7^d5^d4^d2^d1.
  - p0 = ^{d[11:1], p8, p4, p2, p1}, giving even overall parity over all 16 bits.
- FSM: one state per cycle, 4 cycles per message.
  - RD_LO: mem_addr=SRC_BASE+2i; capture mem_rd_data into d[8:1]; go to RD_HI.
  - RD_HI: mem_addr=SRC_BASE+2i+1; capture mem_rd_data[2:0] into d[11:9]; go to WR_LO.
  - WR_LO: mem_addr=DST_BASE+2i, mem_wr_en=1, mem_wr_data=cw[7:0]; go to WR_HI.
  - WR_HI: mem_addr=DST_BASE+2i+1, mem_wr_en=1, mem_wr_data=cw[15:8].
    - If i==NUM_MSG-1, go to DONE.
    - Otherwise i<=i+1 and go to RD_LO.
  - DONE: done=1, mem_wr_en=0, mem_addr held at its last value; stays in DONE until reset.
- mem_wr_en and mem_wr_data are registered-state decodes (Moore) and are high only in WR_LO and WR_HI.
- Latency: with reset deasserted before edge 0, done is observed high 4*NUM_MSG cycles later (60 for the default).
- Parity is computed combinationally from the data register. No arithmetic overflow is possible: the index counter is ceil(log2(NUM_MSG)) bits and never wraps before DONE.
- Overlapping source and destination regions are not supported; the caller guarantees separation.

Test Plan:
- Message d=11'h000 at mem[0..1] -> mem[30]=8'h00, mem[31]=8'h00.
- Message d=11'h7FF (mem[0]=8'hFF, mem[1]=8'h07) -> mem[30]=8'hFF, mem[31]=8'hFF.
- Message d=11'h001 -> codeword 16'h000F (mem[30]=8'h0F, mem[31]=8'h00).
- Message d=11'h400 -> codeword 16'h8117.
- Garbage high bits: mem[1]=8'hF8, mem[0]=8'h00 -> codeword 16'h0000 (bits [7:3] ignored).
- 15 random messages:
  - All codewords match the reference equations.
  - Each codeword has even 16-bit parity.
  - done rises exactly 60 cycles after reset release and stays high.
  - mem_wr_en pulses exactly 30 times.
  - Feeding the outputs through the program-2 decoder with no injected flips returns {5'b00000, d}.
- Reset mid-run: assert reset at cycle 25 -> mem_wr_en is 0 during and after the reset cycle and done=0. After release, the full run completes with correct results and done at +60 cycles.
